tcam_sched: RTL and testbench

- Request scheduler in front of the TCAM + value-SRAM lookup datapath.
- Arbitrates a pipelined search requester against a table-update requester that writes key/mask and value.
- Guarantees an update never overlaps an in-flight search, so the value SRAM is never re-addressed by a write mid-lookup.
- Returns tagged, in-order search responses.

---
 rtl/tcam_sched.sv | 252 +++++++++++++++++++++++++
 tb/tb_tcam_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_sched.sv
// Request scheduler for the TCAM + value-SRAM lookup datapath: search/update arbitration and tagged in-order responses.
// Define TCAM_SCHED_STATS_EN to add saturating search/hit/update statistics counters with a stat_clr input.
module tcam_sched #(
    parameter int  KEY_WIDTH   = 32,
    parameter int  VALUE_WIDTH = 32,
    parameter int  DEPTH       = 16,
    parameter int  TAG_WIDTH   = 4,
    parameter int  LAT         = 2,
    parameter int  MAX_BURST   = 8,
    localparam int ADDR_W      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [KEY_WIDTH-1:0]   s_key,
    input  logic [TAG_WIDTH-1:0]   s_tag,
    input  logic                   u_valid,
    output logic                   u_ready,
    input  logic [ADDR_W-1:0]      u_addr,
    input  logic [KEY_WIDTH-1:0]   u_key,
    input  logic [KEY_WIDTH-1:0]   u_mask,
    input  logic [VALUE_WIDTH-1:0] u_value,
    output logic                   t_search_vld,
    output logic [KEY_WIDTH-1:0]   t_search_key,
    output logic                   t_key_we,
    output logic [ADDR_W-1:0]      t_key_addr,
    output logic [KEY_WIDTH-1:0]   t_key_data,
    output logic [KEY_WIDTH-1:0]   t_key_mask,
    output logic                   t_val_we,
    output logic [ADDR_W-1:0]      t_val_addr,
    output logic [VALUE_WIDTH-1:0] t_val_data,
    input  logic                   t_resp_vld,
    input  logic                   t_resp_hit,
    input  logic [ADDR_W-1:0]      t_resp_addr,
    input  logic [VALUE_WIDTH-1:0] t_resp_data,
    output logic                   r_valid,
    output logic                   r_hit,
    output logic [ADDR_W-1:0]      r_addr,
    output logic [VALUE_WIDTH-1:0] r_data,
    output logic [TAG_WIDTH-1:0]   r_tag,
    output logic                   busy
`ifdef TCAM_SCHED_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [31:0]            stat_search,
    output logic [31:0]            stat_hit,
    output logic [31:0]            stat_update
`endif
);
    localparam int CNT_W   = $clog2(LAT + 1);
    localparam int PTR_W   = (LAT > 1) ? $clog2(LAT) : 1;
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, UPD_KEY, UPD_VAL} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d;
    logic [BURST_W-1:0]     burst_q, burst_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TAG_WIDTH-1:0]   tag_mem_q [LAT];
    logic [ADDR_W-1:0]      upd_addr_q, upd_addr_d;
    logic [VALUE_WIDTH-1:0] upd_val_q, upd_val_d;
    logic                   r_valid_q, r_hit_q;
    logic [ADDR_W-1:0]      r_addr_q;
    logic [VALUE_WIDTH-1:0] r_data_q;
    logic [TAG_WIDTH-1:0]   r_tag_q;
    logic                   resp_acc_s, full_s, burst_lim_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LAT - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // Responses only count against an outstanding search; the pipeline is full when nothing retires this cycle.
    always_comb begin
        resp_acc_s  = t_resp_vld && (inflight_q != {CNT_W{1'b0}});
        full_s      = (inflight_q == CNT_W'(LAT)) && !resp_acc_s;
        burst_lim_s = (burst_q >= BURST_W'(MAX_BURST));
    end

    // Scheduler FSM next-state and datapath strobes.
    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        upd_addr_d   = upd_addr_q;
        upd_val_d    = upd_val_q;
        s_ready      = 1'b0;
        u_ready      = 1'b0;
        t_search_vld = 1'b0;
        t_search_key = {KEY_WIDTH{1'b0}};
        t_key_we     = 1'b0;
        t_key_addr   = {ADDR_W{1'b0}};
        t_key_data   = {KEY_WIDTH{1'b0}};
        t_key_mask   = {KEY_WIDTH{1'b0}};
        t_val_we     = 1'b0;
        t_val_addr   = {ADDR_W{1'b0}};
        t_val_data   = {VALUE_WIDTH{1'b0}};
        if (rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    s_ready = !(u_valid && burst_lim_s) && !full_s;
                    if (s_valid && s_ready) begin
                        t_search_vld = 1'b1;
                        t_search_key = s_key;
                    end else begin
                        t_search_vld = 1'b0;
                    end
                    if (!u_valid) begin
                        burst_d = {BURST_W{1'b0}};
                    end else if (t_search_vld) begin
                        burst_d = burst_q + BURST_W'(1);
                    end else begin
                        burst_d = burst_q;
                    end
                    if (u_valid && (!s_valid || burst_lim_s)) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DRAIN: begin
                    if (inflight_q == {CNT_W{1'b0}}) begin
                        state_d = UPD_KEY;
                    end else begin
                        state_d = DRAIN;
                    end
                end
                UPD_KEY: begin
                    t_key_we   = 1'b1;
                    t_key_addr = u_addr;
                    t_key_data = u_key;
                    t_key_mask = u_mask;
                    u_ready    = 1'b1;
                    upd_addr_d = u_addr;
                    upd_val_d  = u_value;
                    burst_d    = {BURST_W{1'b0}};
                    state_d    = UPD_VAL;
                end
                UPD_VAL: begin
                    t_val_we   = 1'b1;
                    t_val_addr = upd_addr_q;
                    t_val_data = upd_val_q;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outstanding-search count and tag FIFO pointers move together.
    always_comb begin
        inflight_d = inflight_q;
        wr_ptr_d   = t_search_vld ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = resp_acc_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        if (t_search_vld && !resp_acc_s) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!t_search_vld && resp_acc_s) begin
            inflight_d = inflight_q - CNT_W'(1);
        end else begin
            inflight_d = inflight_q;
        end
    end

    // Tag FIFO storage; occupancy lives in the pointers so it needs no reset.
    always_ff @(posedge clk) begin
        if (t_search_vld) begin
            tag_mem_q[wr_ptr_q] <= s_tag;
        end
    end

    // State, counters and the registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= {CNT_W{1'b0}};
            burst_q    <= {BURST_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            upd_addr_q <= {ADDR_W{1'b0}};
            upd_val_q  <= {VALUE_WIDTH{1'b0}};
            r_valid_q  <= 1'b0;
            r_hit_q    <= 1'b0;
            r_addr_q   <= {ADDR_W{1'b0}};
            r_data_q   <= {VALUE_WIDTH{1'b0}};
            r_tag_q    <= {TAG_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            burst_q    <= burst_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            upd_addr_q <= upd_addr_d;
            upd_val_q  <= upd_val_d;
            r_valid_q  <= resp_acc_s;
            r_hit_q    <= resp_acc_s && t_resp_hit;
            r_addr_q   <= (resp_acc_s && t_resp_hit) ? t_resp_addr : {ADDR_W{1'b0}};
            r_data_q   <= (resp_acc_s && t_resp_hit) ? t_resp_data : {VALUE_WIDTH{1'b0}};
            r_tag_q    <= resp_acc_s ? tag_mem_q[rd_ptr_q] : {TAG_WIDTH{1'b0}};
        end
    end

    assign r_valid = r_valid_q;
    assign r_hit   = r_hit_q;
    assign r_addr  = r_addr_q;
    assign r_data  = r_data_q;
    assign r_tag   = r_tag_q;
    assign busy    = !rst && ((state_q != IDLE) || (inflight_q != {CNT_W{1'b0}}));

`ifdef TCAM_SCHED_STATS_EN
    logic [31:0] st_search_q, st_hit_q, st_update_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
    endfunction

    // Saturating statistics; a clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            st_search_q <= 32'd0;
            st_hit_q    <= 32'd0;
            st_update_q <= 32'd0;
        end else begin
            st_search_q <= sat_inc(st_search_q, t_search_vld);
            st_hit_q    <= sat_inc(st_hit_q, resp_acc_s && t_resp_hit);
            st_update_q <= sat_inc(st_update_q, state_q == UPD_VAL);
        end
    end

    assign stat_search = st_search_q;
    assign stat_hit    = st_hit_q;
    assign stat_update = st_update_q;
`endif

    tcam_sched_chk u_chk (
        .clk        (clk),
        .rst        (rst),
        .t_resp_vld (t_resp_vld),
        .fifo_empty (inflight_q == {CNT_W{1'b0}})
    );
endmodule

module tcam_sched_chk (
    input logic clk,
    input logic rst,
    input logic t_resp_vld,
    input logic fifo_empty
);
    // A datapath response with no outstanding search means scheduler and datapath disagree on occupancy.
    assert property (@(posedge clk) disable iff (rst) !(t_resp_vld && fifo_empty));
endmodule

// File: tb/tb_tcam_sched.sv
// Directed self-checking bench for tcam_sched with a behavioural TCAM/value-SRAM datapath of latency LAT.
module tb_tcam_sched;
    localparam int KW = 32, VW = 32, DEPTH = 16, TW = 4, LAT = 2, MAXB = 8, AW = 4;

    logic clk, rst;
    logic s_valid, s_ready, u_valid, u_ready;
    logic [KW-1:0] s_key, u_key, u_mask, t_search_key, t_key_data, t_key_mask;
    logic [TW-1:0] s_tag, r_tag;
    logic [AW-1:0] u_addr, t_key_addr, t_val_addr, t_resp_addr, r_addr;
    logic [VW-1:0] u_value, t_val_data, t_resp_data, r_data;
    logic t_search_vld, t_key_we, t_val_we, t_resp_vld, t_resp_hit, r_valid, r_hit, busy;
`ifdef TCAM_SCHED_STATS_EN
    logic stat_clr;
    logic [31:0] stat_search, stat_hit, stat_update;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tcam_sched #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW), .DEPTH(DEPTH), .TAG_WIDTH(TW),
                 .LAT(LAT), .MAX_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_key(s_key), .s_tag(s_tag),
        .u_valid(u_valid), .u_ready(u_ready), .u_addr(u_addr), .u_key(u_key),
        .u_mask(u_mask), .u_value(u_value),
        .t_search_vld(t_search_vld), .t_search_key(t_search_key),
        .t_key_we(t_key_we), .t_key_addr(t_key_addr), .t_key_data(t_key_data), .t_key_mask(t_key_mask),
        .t_val_we(t_val_we), .t_val_addr(t_val_addr), .t_val_data(t_val_data),
        .t_resp_vld(t_resp_vld), .t_resp_hit(t_resp_hit), .t_resp_addr(t_resp_addr), .t_resp_data(t_resp_data),
        .r_valid(r_valid), .r_hit(r_hit), .r_addr(r_addr), .r_data(r_data), .r_tag(r_tag),
        .busy(busy)
`ifdef TCAM_SCHED_STATS_EN
        , .stat_clr(stat_clr), .stat_search(stat_search), .stat_hit(stat_hit), .stat_update(stat_update)
`endif
    );

    // Behavioural datapath: lowest matching index wins, result appears LAT cycles after issue.
    logic [KW-1:0] m_key [DEPTH];
    logic [KW-1:0] m_mask [DEPTH];
    logic [VW-1:0] m_val [DEPTH];
    logic          m_vld [DEPTH];
    logic          pv [LAT];
    logic          ph [LAT];
    logic [AW-1:0] pa [LAT];
    logic [VW-1:0] pd [LAT];

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_vld[i] = 1'b0; m_val[i] = '0; m_key[i] = '0; m_mask[i] = '0;
        end
        for (int p = 0; p < LAT; p++) begin
            pv[p] = 1'b0; ph[p] = 1'b0; pa[p] = '0; pd[p] = '0;
        end
    end

    always @(posedge clk) begin
        logic h;
        logic [AW-1:0] a;
        h = 1'b0;
        a = AW'(3);  // junk index on a miss; the scheduler must zero it
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (m_vld[i] && (((t_search_key ^ m_key[i]) & m_mask[i]) == '0)) begin
                h = 1'b1;
                a = AW'(i);
            end
        end
        cyc_cnt <= cyc_cnt + 1;
        if (rst) begin
            for (int p = 0; p < LAT; p++) pv[p] <= 1'b0;
        end else begin
            pv[0] <= t_search_vld; ph[0] <= h; pa[0] <= a; pd[0] <= m_val[a];
            for (int p = 1; p < LAT; p++) begin
                pv[p] <= pv[p-1]; ph[p] <= ph[p-1]; pa[p] <= pa[p-1]; pd[p] <= pd[p-1];
            end
            if (t_key_we) begin
                m_key[t_key_addr] <= t_key_data;
                m_mask[t_key_addr] <= t_key_mask;
                m_vld[t_key_addr] <= 1'b1;
            end
            if (t_val_we) m_val[t_val_addr] <= t_val_data;
        end
    end

    assign t_resp_vld  = pv[LAT-1];
    assign t_resp_hit  = ph[LAT-1];
    assign t_resp_addr = pa[LAT-1];
    assign t_resp_data = pd[LAT-1];

    typedef struct packed {
        logic          hit;
        logic [AW-1:0] addr;
        logic [VW-1:0] data;
        logic [TW-1:0] tag;
        logic [31:0]   cyc;
    } resp_t;
    resp_t rq [$];

    always @(negedge clk) begin
        if (r_valid === 1'b1) rq.push_back({r_hit, r_addr, r_data, r_tag, 32'(cyc_cnt)});
    end

    typedef struct {
        logic [KW-1:0] key;
        logic [TW-1:0] tag;
        logic          hit;
        logic [AW-1:0] addr;
        logic [VW-1:0] data;
    } vec_t;
    vec_t vt [6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk); #1;
    endtask

    task automatic wait_resp(input int want, output int d);
        d = -1;
        for (int k = 1; k <= 20 && d < 0; k++) begin
            samp();
            if (rq.size() >= want) d = k;
        end
        check("resp_arrived", 64'(d >= 0), 64'd1);
    endtask

    // Full update from an idle, empty pipeline; returns in the UPD_VAL cycle.
    task automatic do_update(input logic [AW-1:0] a, input logic [KW-1:0] k,
                             input logic [KW-1:0] m, input logic [VW-1:0] v);
        int lat;
        u_addr = a; u_key = k; u_mask = m; u_value = v; u_valid = 1'b1;
        lat = -1;
        for (int i = 0; i < 50 && lat < 0; i++) begin
            samp();
            if (u_ready === 1'b1) lat = i;
        end
        next_cyc();
        u_valid = 1'b0;
        check("upd_cost", 64'(lat), 64'd2);
    endtask

    initial begin
        int d, base, phase, grants0, grants_all, srch_upd, key_cyc, val_cyc, resp_at_key;
        logic granted, drop_u, busy_at_key;
        logic [KW-1:0] skeys [4];

        rst = 1'b1; s_valid = 1'b0; s_key = '0; s_tag = '0; u_valid = 1'b0;
        u_addr = '0; u_key = '0; u_mask = '0; u_value = '0;
`ifdef TCAM_SCHED_STATS_EN
        stat_clr = 1'b0;
`endif
        @(posedge clk); #1;
        samp();
        check("rst_s_ready", 64'(s_ready), 64'd0);
        next_cyc();
        rst = 1'b0;
        samp();
        check("rst_state_s_ready", 64'(s_ready), 64'd1);
        check("rst_state_busy", 64'(busy), 64'd0);
        check("rst_state_r_valid", 64'(r_valid), 64'd0);
        check("rst_state_u_ready", 64'(u_ready), 64'd0);
        check("rst_state_we", {62'd0, t_key_we, t_val_we}, 64'd0);
        check("rst_state_r_tag_data", {28'd0, r_tag, r_data}, 64'd0);
        next_cyc();

        // Table contents for the lookups below.
        do_update(4'd3, 32'hA5A5_0000, 32'hFFFF_0000, 32'h0000_1234); next_cyc();
        do_update(4'd0, 32'h1000_0000, 32'hF000_0000, 32'h0000_BEEF); next_cyc();
        do_update(4'd5, 32'h0000_1111, 32'hFFFF_FFFF, 32'h0000_5555); next_cyc();

        // Single search: response three cycles after the handshake.
        base = rq.size();
        s_key = 32'hA5A5_BEEF; s_tag = 4'd7; s_valid = 1'b1;
        samp();
        check("single_ready", 64'(s_ready), 64'd1);
        next_cyc();
        s_valid = 1'b0;
        wait_resp(base + 1, d);
        check("single_latency", 64'(d), 64'd3);
        if (rq.size() > base) begin
            check("single_hit", 64'(rq[base].hit), 64'd1);
            check("single_addr", 64'(rq[base].addr), 64'd3);
            check("single_data", 64'(rq[base].data), 64'h1234);
            check("single_tag", 64'(rq[base].tag), 64'd7);
        end
        next_cyc();

        // Back-to-back searches from a vector table.
        vt[0] = '{32'hA5A5_BEEF, 4'd0, 1'b1, 4'd3, 32'h0000_1234};
        vt[1] = '{32'h1234_5678, 4'd1, 1'b1, 4'd0, 32'h0000_BEEF};
        vt[2] = '{32'h0000_1111, 4'd2, 1'b1, 4'd5, 32'h0000_5555};
        vt[3] = '{32'hFFFF_FFFF, 4'd3, 1'b0, 4'd0, 32'h0000_0000};
        vt[4] = '{32'h1FFF_0000, 4'd4, 1'b1, 4'd0, 32'h0000_BEEF};
        vt[5] = '{32'hA5A5_0000, 4'd5, 1'b1, 4'd3, 32'h0000_1234};
        base = rq.size();
        for (int i = 0; i < 6; i++) begin
            s_key = vt[i].key; s_tag = vt[i].tag; s_valid = 1'b1;
            samp();
            check("b2b_ready", 64'(s_ready), 64'd1);
            next_cyc();
        end
        s_valid = 1'b0;
        wait_resp(base + 6, d);
        for (int i = 0; i < 6; i++) begin
            if (rq.size() > base + i) begin
                check($sformatf("b2b_hit_%0d", i), 64'(rq[base+i].hit), 64'(vt[i].hit));
                check($sformatf("b2b_addr_%0d", i), 64'(rq[base+i].addr), 64'(vt[i].addr));
                check($sformatf("b2b_data_%0d", i), 64'(rq[base+i].data), 64'(vt[i].data));
                check($sformatf("b2b_tag_%0d", i), 64'(rq[base+i].tag), 64'(vt[i].tag));
                check($sformatf("b2b_cycle_%0d", i), 64'(rq[base+i].cyc), 64'(rq[base].cyc) + 64'(i));
            end
        end
        next_cyc();

        // Read-after-update: search raised in the cycle after u_ready.
        do_update(4'd5, 32'h0000_1111, 32'hFFFF_FFFF, 32'h0000_CAFE);
        base = rq.size();
        s_key = 32'h0000_1111; s_tag = 4'd9; s_valid = 1'b1;
        d = -1;
        for (int i = 0; i < 20 && d < 0; i++) begin
            samp();
            if (s_ready === 1'b1) d = i;
        end
        check("rau_ready_after", 64'(d), 64'd1);
        next_cyc();
        s_valid = 1'b0;
        wait_resp(base + 1, d);
        if (rq.size() > base) begin
            check("rau_hit", 64'(rq[base].hit), 64'd1);
            check("rau_addr", 64'(rq[base].addr), 64'd5);
            check("rau_data", 64'(rq[base].data), 64'hCAFE);
            check("rau_tag", 64'(rq[base].tag), 64'd9);
        end
        next_cyc();

        // Collision: searches and an update requested together for 20 cycles.
        base = rq.size();
        s_key = 32'hFFFF_0000; s_tag = 4'd0; s_valid = 1'b1;
        u_addr = 4'd9; u_key = 32'h9999_9999; u_mask = 32'hFFFF_FFFF; u_value = 32'h0000_0099; u_valid = 1'b1;
        phase = 0; grants0 = 0; grants_all = 0; srch_upd = 0;
        key_cyc = -1; val_cyc = -1; resp_at_key = -1; busy_at_key = 1'b0;
        for (int c = 0; c < 20; c++) begin
            samp();
            if (t_key_we === 1'b1) begin
                phase = 1; key_cyc = c; resp_at_key = rq.size() - base; busy_at_key = busy;
            end
            if (t_search_vld === 1'b1) begin
                grants_all++;
                if (phase == 0) grants0++;
                else if (phase == 1) srch_upd++;
            end
            if (t_val_we === 1'b1) begin
                val_cyc = c; phase = 2;
            end
            granted = t_search_vld;
            drop_u = u_ready;
            next_cyc();
            if (granted) s_tag = s_tag + 4'd1;
            if (drop_u) u_valid = 1'b0;
        end
        s_valid = 1'b0;
        for (int c = 0; c < 8; c++) samp();
        check("coll_burst_grants", 64'(grants0), 64'd8);
        check("coll_key_cycle", 64'(key_cyc), 64'd11);
        check("coll_val_cycle", 64'(val_cyc), 64'd12);
        check("coll_search_in_update", 64'(srch_upd), 64'd0);
        check("coll_drained_at_key", 64'(resp_at_key), 64'd8);
        check("coll_busy_at_key", 64'(busy_at_key), 64'd1);
        check("coll_total_grants", 64'(grants_all), 64'd15);
        check("coll_resp_count", 64'(rq.size() - base), 64'd15);
        for (int i = 0; i < 15; i++) begin
            if (rq.size() > base + i) check($sformatf("coll_tag_%0d", i), 64'(rq[base+i].tag), 64'(i));
        end
        next_cyc();

        // Reset with two searches in flight.
        s_key = 32'hA5A5_BEEF; s_tag = 4'd1; s_valid = 1'b1;
        samp(); next_cyc();
        s_tag = 4'd2;
        samp(); next_cyc();
        s_valid = 1'b0; rst = 1'b1;
        samp();
        check("rstA_s_ready_in_rst", 64'(s_ready), 64'd0);
        check("rstA_busy_in_rst", 64'(busy), 64'd0);
        next_cyc();
        rst = 1'b0;
        base = rq.size();
        samp();
        check("rstA_s_ready_post", 64'(s_ready), 64'd1);
        check("rstA_busy_post", 64'(busy), 64'd0);
        check("rstA_r_valid_post", 64'(r_valid), 64'd0);
        for (int c = 0; c < 6; c++) samp();
        check("rstA_no_resp", 64'(rq.size() - base), 64'd0);
        next_cyc();

        // Reset while in UPD_KEY.
        u_addr = 4'd7; u_key = 32'h7777_7777; u_mask = 32'hFFFF_FFFF; u_value = 32'h77; u_valid = 1'b1;
        d = -1;
        for (int i = 0; i < 50 && d < 0; i++) begin
            samp();
            if (u_ready === 1'b1) d = i;
        end
        check("rstB_reach_upd_key", 64'(d), 64'd2);
        rst = 1'b1;
        #1;
        check("rstB_key_we_in_rst", {62'd0, t_key_we, u_ready}, 64'd0);
        next_cyc();
        rst = 1'b0; u_valid = 1'b0;
        base = rq.size();
        samp();
        check("rstB_busy_post", 64'(busy), 64'd0);
        check("rstB_s_ready_post", 64'(s_ready), 64'd1);
        check("rstB_val_we_post", 64'(t_val_we), 64'd0);
        samp();
        check("rstB_no_resp", 64'(rq.size() - base), 64'd0);
        next_cyc();

`ifdef TCAM_SCHED_STATS_EN
        // Statistics: 4 searches (3 hits) and 2 updates, then a clear.
        stat_clr = 1'b1; next_cyc(); stat_clr = 1'b0;
        skeys[0] = 32'hA5A5_BEEF; skeys[1] = 32'h1234_5678; skeys[2] = 32'h0000_1111; skeys[3] = 32'hFFFF_FFFF;
        base = rq.size();
        for (int i = 0; i < 4; i++) begin
            s_key = skeys[i]; s_tag = 4'(i); s_valid = 1'b1;
            samp(); next_cyc();
        end
        s_valid = 1'b0;
        wait_resp(base + 4, d);
        next_cyc();
        do_update(4'd10, 32'hAAAA_0000, 32'hFFFF_0000, 32'h0A); next_cyc();
        do_update(4'd11, 32'hBBBB_0000, 32'hFFFF_0000, 32'h0B); next_cyc();
        samp();
        check("stat_search", 64'(stat_search), 64'd4);
        check("stat_hit", 64'(stat_hit), 64'd3);
        check("stat_update", 64'(stat_update), 64'd2);
        next_cyc();
        stat_clr = 1'b1; next_cyc(); stat_clr = 1'b0;
        samp();
        check("stat_clr_search", 64'(stat_search), 64'd0);
        check("stat_clr_hit", 64'(stat_hit), 64'd0);
        check("stat_clr_update", 64'(stat_update), 64'd0);
`else
        skeys[0] = '0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end
endmodule
